serial_rx: RTL

UART receiver for 8N1 frames at a fixed baud rate. It takes the raw asynchronous serial line from the board pin or loopback and delivers each received byte with a one-cycle valid pulse. It sits directly downstream of the serial transmitter and shares its clocking scheme: the default is a 54 MHz system clock and 9600 baud, giving 5625 clocks per bit. It flags framing errors and rejects false start bits.

---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_rx_sync.sv | 46 ++++
 rtl/serial_rx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver FSM states, default clocking and frame geometry.
package serial_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 54_000_000;
  localparam int unsigned BAUD_DEFAULT   = 9600;
  localparam int unsigned FRAME_BITS     = 10;
  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/serial_rx_sync.sv
// rx line synchronizer, 3-deep history, start-edge detect and bit sample.
// SERIAL_RX_MAJORITY_EN selects a 2-of-3 majority sample instead of h0.
module serial_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  output logic sample,
  output logic fall_edge
);

  logic sync1;
  logic sync2;
  logic h1;
  logic h0;

  // Idle-high reset so a quiet line never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      h1    <= 1'b1;
      h0    <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      h0    <= sync2;
      h1    <= h0;
    end
  end

  assign fall_edge = h1 & ~h0;

`ifdef SERIAL_RX_MAJORITY_EN
  logic h2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) h2 <= 1'b1;
    else       h2 <= h1;
  end

  assign sample = (h2 & h1) | (h2 & h0) | (h1 & h0);
`else
  assign sample = h0;
`endif

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver: samples at bit centres, pulses rx_valid or rx_frame_err per frame.
// Build with SERIAL_RX_MAJORITY_EN for majority-voted sampling (see serial_rx_sync).
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned CLK_HZ   = CLK_HZ_DEFAULT,
  parameter int unsigned BAUD     = BAUD_DEFAULT,
  parameter int unsigned BIT_CNT  = CLK_HZ / BAUD,
  parameter int unsigned HALF_CNT = BIT_CNT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic sample;
  logic fall_edge;

  rx_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       data_next;
  logic             valid_next;
  logic             err_next;

  serial_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .sample    (sample),
    .fall_edge (fall_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift        <= shift_next;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_frame_err <= err_next;
      rx_busy      <= (state_next != IDLE);
    end
  end

  // Counter is cleared at every sample point and state change, so it never wraps
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    data_next    = rx_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (fall_edge) state_next = START;
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (!sample) begin
            bit_idx_next = '0;
            state_next   = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = sample;
          if (bit_idx == IDX_LAST) state_next = STOP;
          else                     bit_idx_next = bit_idx + 3'd1;
        end
      end

      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next = '0;
          if (sample) begin
            data_next  = shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end

      // Hold off until the line returns high so a break does not retrigger
      WAIT_HIGH: begin
        cnt_next = '0;
        if (sample) state_next = IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule
